// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants, occupancy-width helper and per-stage control bundle
// for the pipe_stage_chain slice.
package pipe_pkg;
   localparam int PERF_CNT_W = 32;
   typedef struct packed {
      logic stall;
      logic flush;
   } stage_ctl_t;
   function automatic int clog2_occ(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one valid/data pipeline register with flush-over-stall priority.
module pipe_stage_reg import pipe_pkg::*; #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  stage_ctl_t       ctl_i,
   input  logic             src_valid_i,
   input  logic [WIDTH-1:0] src_data_i,
   input  logic             take_i,
   output logic             offer_o,
   output logic             rdy_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);
   logic             valid_q, valid_d, ev;
   logic [WIDTH-1:0] data_q, data_d;
   // a stalled stage keeps its payload, so it must not offer it downstream
   always_comb begin
      ev      = valid_q & ~ctl_i.flush;
      rdy_o   = ctl_i.flush | (~ctl_i.stall & (~ev | take_i));
      offer_o = ev & ~ctl_i.stall;
      valid_d = ctl_i.flush ? 1'b0 : rdy_o ? src_valid_i : valid_q;
      data_d  = (rdy_o & src_valid_i) ? src_data_i : data_q;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end
   assign valid_o = valid_q;
   assign data_o  = data_q;
endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH-stage valid/ready register chain with per-stage stall/flush.
// Define PIPE_PERF_CNT_EN to add perf_clr/perf_xfer/perf_bubble transfer counters.
module pipe_stage_chain import pipe_pkg::*; #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [WIDTH-1:0]              in_data,
   output logic                          in_ready,
   input  logic [DEPTH-1:0]              stall,
   input  logic [DEPTH-1:0]              flush,
   output logic                          out_valid,
   output logic [WIDTH-1:0]              out_data,
   input  logic                          out_ready,
`ifdef PIPE_PERF_CNT_EN
   input  logic                          perf_clr,
   output logic [PERF_CNT_W-1:0]         perf_xfer,
   output logic [PERF_CNT_W-1:0]         perf_bubble,
`endif
   output logic [clog2_occ(DEPTH)-1:0]   occ
);
   localparam int OCC_W = clog2_occ(DEPTH);
   // index 0 is the upstream port, index i+1 is stage i; rdy[DEPTH] is the sink
   logic [DEPTH:0]   src_v, rdy;
   logic [WIDTH-1:0] data [DEPTH+1];
   logic [DEPTH-1:0] vld;
   assign src_v[0]   = in_valid;
   assign data[0]    = in_data;
   assign rdy[DEPTH] = out_ready;
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      stage_ctl_t ctl;
      assign ctl = '{stall: stall[i], flush: flush[i]};
      pipe_stage_reg #(.WIDTH(WIDTH)) u_stage (
         .clk         (clk),
         .rst         (rst),
         .ctl_i       (ctl),
         .src_valid_i (src_v[i]),
         .src_data_i  (data[i]),
         .take_i      (rdy[i+1]),
         .offer_o     (src_v[i+1]),
         .rdy_o       (rdy[i]),
         .valid_o     (vld[i]),
         .data_o      (data[i+1])
      );
   end
   assign in_ready  = rdy[0];
   assign out_valid = vld[DEPTH-1] & ~flush[DEPTH-1];
   assign out_data  = data[DEPTH];
   always_comb begin
      occ = '0;
      for (int k = 0; k < DEPTH; k++) occ = occ + OCC_W'(vld[k]);
   end
`ifdef PIPE_PERF_CNT_EN
   logic [PERF_CNT_W-1:0] xfer_q, xfer_d, bub_q, bub_d;
   always_comb begin
      xfer_d = perf_clr ? '0 : xfer_q + PERF_CNT_W'(out_valid & out_ready);
      bub_d  = perf_clr ? '0 : bub_q + PERF_CNT_W'(out_ready & ~out_valid);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         xfer_q <= '0;
         bub_q  <= '0;
      end else begin
         xfer_q <= xfer_d;
         bub_q  <= bub_d;
      end
   end
   assign perf_xfer   = xfer_q;
   assign perf_bubble = bub_q;
`endif
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: table-driven directed bench for pipe_stage_chain (WIDTH=8, DEPTH=4).
module tb_pipe_stage_chain;
   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [7:0] in_data, out_data;
   logic [3:0] stall, flush;
   logic [2:0] occ;
`ifdef PIPE_PERF_CNT_EN
   logic        perf_clr;
   logic [31:0] perf_xfer, perf_bubble;
`endif
   int passed = 0;
   int total  = 0;

   pipe_stage_chain #(.WIDTH(8), .DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .stall       (stall),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
`ifdef PIPE_PERF_CNT_EN
      .perf_clr    (perf_clr),
      .perf_xfer   (perf_xfer),
      .perf_bubble (perf_bubble),
`endif
      .occ         (occ)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       iv;
      logic [7:0] id;
      logic [3:0] st;
      logic [3:0] fl;
      logic       ordy;
      logic       eir;
      logic       eov;
      logic [7:0] eod;
      logic [2:0] eocc;
   } vec_t;
   vec_t v [33];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   task automatic setv(input int k, input int iv, input int id, input int st, input int fl,
                       input int ordy, input int eir, input int eov, input int eod, input int eocc);
      v[k].iv = 1'(iv);   v[k].id = 8'(id);    v[k].st = 4'(st);   v[k].fl = 4'(fl);
      v[k].ordy = 1'(ordy); v[k].eir = 1'(eir); v[k].eov = 1'(eov);
      v[k].eod = 8'(eod); v[k].eocc = 3'(eocc);
   endtask

   initial begin
      int cyc;
      // free flow: payload k+1 enters on row k, first output after 4 edges
      for (int k = 0; k < 8; k++)
         setv(k, 1, k + 1, 0, 0, 1, 1, int'(k >= 4), (k >= 4) ? k - 3 : 0, (k < 4) ? k : 4);
      // stall stage 1 on a full pipe: stages 2-3 drain, upstream holds
      setv(8,  1, 9,  2, 0, 1, 0, 1, 5,  4);
      setv(9,  1, 9,  2, 0, 1, 0, 1, 6,  3);
      setv(10, 1, 9,  2, 0, 1, 0, 0, 6,  2);
      setv(11, 1, 9,  0, 0, 1, 1, 0, 6,  2);
      setv(12, 1, 10, 0, 0, 1, 1, 0, 6,  3);
      setv(13, 1, 11, 0, 0, 1, 1, 1, 7,  4);
      setv(14, 1, 12, 0, 0, 1, 1, 1, 8,  4);
      setv(15, 1, 13, 0, 0, 1, 1, 1, 9,  4);
      // stages 3..0 hold 10,11,12,13; squash stages 1 and 0
      setv(16, 0, 0,  0, 3, 1, 1, 1, 10, 4);
      setv(17, 0, 0,  0, 0, 1, 1, 1, 11, 1);
      setv(18, 0, 0,  0, 0, 1, 1, 0, 11, 0);
      // back-pressure: six cycles with out_ready low, only four accepted
      setv(19, 1, 20, 0, 0, 0, 1, 0, 11, 0);
      setv(20, 1, 21, 0, 0, 0, 1, 0, 11, 1);
      setv(21, 1, 22, 0, 0, 0, 1, 0, 11, 2);
      setv(22, 1, 23, 0, 0, 0, 1, 0, 11, 3);
      setv(23, 1, 24, 0, 0, 0, 0, 1, 20, 4);
      setv(24, 1, 24, 0, 0, 0, 0, 1, 20, 4);
      setv(25, 1, 24, 0, 0, 1, 1, 1, 20, 4);
      setv(26, 0, 0,  0, 0, 1, 1, 1, 21, 4);
      setv(27, 0, 0,  0, 0, 1, 1, 1, 22, 3);
      setv(28, 0, 0,  0, 0, 1, 1, 1, 23, 2);
      setv(29, 0, 0,  0, 0, 1, 1, 1, 24, 1);
      setv(30, 0, 0,  0, 0, 1, 1, 0, 24, 0);
      // stall+flush on stage 0: accepted payload is dropped
      setv(31, 1, 30, 1, 1, 1, 1, 0, 24, 0);
      setv(32, 0, 0,  0, 0, 1, 1, 0, 24, 0);

      rst = 1'b0; in_valid = 1'b0; in_data = '0; stall = '0; flush = '0; out_ready = 1'b0;
`ifdef PIPE_PERF_CNT_EN
      perf_clr = 1'b0;
`endif
      #1;
      chk("reset out_valid", int'(out_valid), 0);
      chk("reset out_data", int'(out_data), 0);
      chk("reset occ", int'(occ), 0);
      @(negedge clk);
      rst = 1'b1;

      for (int k = 0; k < 33; k++) begin
         @(negedge clk);
         in_valid = v[k].iv; in_data = v[k].id; stall = v[k].st; flush = v[k].fl;
         out_ready = v[k].ordy;
         #1;
         chk($sformatf("row%0d in_ready", k), int'(in_ready), int'(v[k].eir));
         chk($sformatf("row%0d out_valid", k), int'(out_valid), int'(v[k].eov));
         chk($sformatf("row%0d out_data", k), int'(out_data), int'(v[k].eod));
         chk($sformatf("row%0d occ", k), int'(occ), int'(v[k].eocc));
      end

      // async reset with three payloads in flight
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = 8'(40 + k); stall = '0; flush = '0; out_ready = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("pre-reset occ", int'(occ), 3);
      #2 rst = 1'b0;
      #1;
      chk("async reset out_valid", int'(out_valid), 0);
      chk("async reset occ", int'(occ), 0);
      chk("async reset out_data", int'(out_data), 0);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1; in_data = 8'd50;
      cyc = 0;
      while (cyc < 10) begin
         @(posedge clk);
         #1;
         cyc++;
         in_valid = 1'b0;
         if (out_valid) break;
      end
      chk("post-reset latency", cyc, 4);
      chk("post-reset out_data", int'(out_data), 50);

`ifdef PIPE_PERF_CNT_EN
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b0; perf_clr = 1'b1;
      @(negedge clk);
      perf_clr = 1'b0; in_valid = 1'b1; in_data = 8'd60;
      repeat (8) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      repeat (2) @(negedge clk);
      out_ready = 1'b0;
      #1;
      chk("perf_xfer", int'(perf_xfer), 5);
      chk("perf_bubble", int'(perf_bubble), 2);
      @(negedge clk);
      perf_clr = 1'b1;
      @(negedge clk);
      perf_clr = 1'b0;
      #1;
      chk("perf_xfer cleared", int'(perf_xfer), 0);
      chk("perf_bubble cleared", int'(perf_bubble), 0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised chain of DEPTH pipeline registers, each carrying WIDTH-bit payload plus a valid bit.
- Per-stage stall (hold) and flush (kill) controls.
- Valid/ready handshake at both ends.
- Generic backbone for the CPU's IF/ID/EX/MEM/WB register boundaries: bubble insertion, hold, squash, and back-pressure in one block instead of hand-written per-stage enables.

Parameters:
- WIDTH, 32, payload width per stage in bits (≥1).
- DEPTH, 4, number of register stages (≥1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- in_valid  input  1  upstream offers in_data
- in_data  input  WIDTH  upstream payload
- in_ready  output  1  stage 0 accepts this cycle
- stall  input  DEPTH  bit i: stage i holds its content
- flush  input  DEPTH  bit i: stage i content discarded
- out_valid  output  1  stage DEPTH-1 holds live payload
- out_data  output  WIDTH  stage DEPTH-1 payload
- out_ready  input  1  downstream consumes out_data
- occ  output  $clog2(DEPTH+1)  number of valid stages (registered view)

Behaviour:
- State: valid[i] and data[i] for i = 0..DEPTH-1.
- Reset (rst=0, async):
  - All valid[i] = 0; all data[i] = 0.
  - out_valid = 0, out_data = 0, occ = 0.
  - Reset asserted mid-operation drops all in-flight payloads immediately. No drain.
- Effective valid: ev[i] = valid[i] & ~flush[i]. A flushed stage never passes data downstream.
- Downstream acceptance:
  - take[DEPTH-1] = out_ready.
  - take[i] = rdy[i+1] for i < DEPTH-1.
- Stage ready: rdy[i] = flush[i] | (~stall[i] & (~ev[i] | take[i])).
  - flush overrides stall.
  - An empty, non-stalled stage is always ready.
  - This is a combinational chain from out_ready to in_ready, depth DEPTH.
- in_ready = rdy[0].
- Stage i source:
  - Stage 0 sources in_valid/in_data.
  - Stage i>0 sources ev[i-1]/data[i-1].
- Update per edge, in priority order:
  - flush[i]: valid[i] <= 0. data[i] is don't-care; the implementation loads the source payload.
  - else if rdy[i]: valid[i] <= source valid; data[i] <= source data. A 0 source valid inserts a bubble.
  - else: hold.
- Data gating: data[i] is written only when the source valid is 1. Bubbles leave data unchanged, which keeps switching low.
- Outputs:
  - out_valid = ev[DEPTH-1].
  - out_data = data[DEPTH-1].
  - Transfer occurs on out_valid & out_ready.
- Latency and throughput: DEPTH cycles from in accept to out_valid when no stall/flush; sustained 1 transfer/cycle.
- Stall on a full stage:
  - Stage holds.
  - Upstream full stages hold; upstream empty stages still fill. Bubbles collapse.
- Stall on an empty stage: holds the empty slot. Upstream back-pressures once the preceding stages are full.
- Simultaneous stall[i] and flush[i]: flush wins. Stage becomes empty and accepts the upstream payload, which is also dropped.
- Flush of the last stage with out_ready=1: no transfer (out_valid=0).
- occ = popcount(valid) sampled after the edge. Flush takes effect the next cycle.
- in_valid with in_ready=0: the upstream holds in_data stable. The block does not latch it.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_xfer[31:0] and perf_bubble[31:0].
  - perf_xfer counts cycles with out_valid & out_ready.
  - perf_bubble counts cycles with out_ready & ~out_valid.
  - Both are reset to 0, wrap modulo 2^32, and are cleared by an input perf_clr (synchronous, active-high, priority over increment).
- Undefined: ports, counters, and perf_clr are absent. Behaviour is otherwise identical.

Decomposition:
- Package pipe_pkg:
  - PERF_CNT_W = 32.
  - Function clog2_occ(DEPTH) for the occ width.
  - typedef stage_ctl_t {stall, flush}.
- One sub-module: pipe_stage_reg, a single stage (valid/data register, rdy/ev logic, flush/stall priority).
  - Instantiated DEPTH times via generate.
  - The top handles the ready chain, occ, and perf counters.

Test Plan:
- Free flow (WIDTH=8, DEPTH=4):
  - Stimulus: in_data = 1,2,3,… every cycle; out_ready=1; no stall/flush.
  - Required: out_data 1 appears at cycle 4; then 2,3,… consecutive; occ=4 steady.
- Hold and collapse:
  - Stimulus: after the pipe is full, stall[1]=1 for 3 cycles with out_ready=1.
  - Required: stages 2–3 drain; out_valid drops after 2 cycles; in_ready=0; after release, values resume in order with no loss or duplicate.
- Squash:
  - Stimulus: with payloads 10,11,12,13 in stages 3..0, pulse flush[1:0]=2'b11 for 1 cycle.
  - Required: outputs are 13? no — 10 then 11; 12 and 13 are never output; occ dips by 2.
- Back-pressure:
  - Stimulus: out_ready=0 for 6 cycles while in_valid=1.
  - Required: exactly 4 payloads accepted; in_ready=0 after the 4th; order preserved on release.
- Async reset mid-flight:
  - Stimulus: assert rst=0 between clock edges with occ=3.
  - Required: out_valid=0, occ=0 immediately; first post-reset payload takes 4 cycles.
- Perf counters (PIPE_PERF_CNT_EN):
  - Stimulus: 5 transfers and 2 empty out_ready cycles.
  - Required: perf_xfer=5, perf_bubble=2; perf_clr then gives 0,0.
